// File: rtl/gf_pow_seq.sv
`default_nettype none

// ============================================================================
//  Module   : x_pow_n
//  Purpose  : Combinational GF(2^8) multiplier, field polynomial
//             x^8+x^6+x^5+x+1 (0x163). The running value x*x^n is formed one
//             shift/reduce step at a time and accumulated where y has a 1 bit.
//  Revision : 1.0  initial release
// ============================================================================
module x_pow_n #(
    parameter logic [7:0] POLY_LO = 8'h63   // low byte of 0x163
) (
    input  logic [7:0] x_i,
    input  logic [7:0] y_i,
    output logic [7:0] z_o
);

    logic [7:0] w_xn;
    logic [7:0] w_acc;

    // Shift-and-add product: w_xn walks through x*x^i, reduced after each shift
    always_comb begin
        w_xn  = x_i;
        w_acc = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (y_i[i]) begin
                w_acc = w_acc ^ w_xn;
            end
            w_xn = {w_xn[6:0], 1'b0} ^ (w_xn[7] ? POLY_LO : 8'h00);
        end
        z_o = w_acc;
    end

endmodule

// ============================================================================
//  Module   : gf_pow_seq
//  Purpose  : Sequential GF(2^8) exponentiation p = a^e. Left-to-right
//             square-and-multiply over the exponent bits using one shared
//             x_pow_n multiplier. Latency is EXP_W + popcount(e) busy cycles
//             followed by a one-cycle done pulse, independent of a.
//  Revision : 1.0  initial release
// ============================================================================
module gf_pow_seq #(
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       a,
    input  logic [EXP_W-1:0] e,
    output logic             busy,
    output logic             done,
    output logic [7:0]       p
);

    // Exponent bit index width; kept at least one bit wide for EXP_W == 1
    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SQR  = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q;
    logic [7:0]       a_q;
    logic [EXP_W-1:0] e_q;
    logic [7:0]       r_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0]       p_q;

    logic [7:0]       w_mul_x;
    logic [7:0]       w_mul_y;
    logic [7:0]       w_mul_z;

    // Operand select: multiply by the latched base only in MUL, square otherwise
    always_comb begin
        w_mul_x = r_q;
        w_mul_y = (state_q == ST_MUL) ? a_q : r_q;
    end

    x_pow_n #(
        .POLY_LO (8'h63)
    ) u_mul (
        .x_i (w_mul_x),
        .y_i (w_mul_y),
        .z_o (w_mul_z)
    );

    // Scheduler FSM with registered busy/done/p; p is loaded on entry to DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= 8'h00;
            e_q     <= '0;
            r_q     <= 8'h01;
            idx_q   <= IDX_TOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            p_q     <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        e_q     <= e;
                        r_q     <= 8'h01;
                        idx_q   <= IDX_TOP;
                        busy_q  <= 1'b1;
                        state_q <= ST_SQR;
                    end
                end

                ST_SQR: begin
                    r_q <= w_mul_z;
                    if (e_q[idx_q]) begin
                        state_q <= ST_MUL;
                    end else if (idx_q == '0) begin
                        p_q     <= w_mul_z;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                    end
                end

                ST_MUL: begin
                    r_q <= w_mul_z;
                    if (idx_q == '0) begin
                        p_q     <= w_mul_z;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_q - 1'b1;
                        state_q <= ST_SQR;
                    end
                end

                ST_DONE: begin
                    // A start here is taken exactly as in IDLE so operations
                    // can run back-to-back without an idle gap.
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        e_q     <= e;
                        r_q     <= 8'h01;
                        idx_q   <= IDX_TOP;
                        busy_q  <= 1'b1;
                        state_q <= ST_SQR;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule

`default_nettype wire

// File: doc/gf_pow_seq.md
Name: gf_pow_seq

Overview:
- Sequential GF(2^8) exponentiation engine. Computes p = a^e using one shared x_pow_n multiplier instance, over a field reduced by x^8+x^6+x^5+x+1 (0x163).
- Left-to-right square-and-multiply scheduler. Provides the x^247 / x^251 powers for the serialized SEED G-function S-box path.
- Replaces the chained combinational power trees with a single multiplier, trading latency for area.

Parameters:
- EXP_W, 8, exponent width in bits. Also sets the number of square steps per operation.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse. Sampled only when busy=0.
- a  input  8  base operand. Latched on accepted start.
- e  input  EXP_W  exponent. Latched on accepted start.
- busy  output  1  high while an operation is in progress (SQR/MUL states).
- done  output  1  one-cycle pulse when p is valid.
- p  output  8  result register. Holds its value until the next done.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, p=8'h00, internal r=8'h01, idx=EXP_W-1, latched a/e cleared. Takes effect immediately, including mid-operation; the in-flight result is discarded and no done is issued.
- Shared multiplier: a single x_pow_n instance, purely combinational. Operand mux per state:
  - SQR: (r, r)
  - MUL: (r, a_q)
  - IDLE/DONE: (r, r), output unused
- States:
  - IDLE: busy=0. On start=1, latch a_q<=a, e_q<=e, r<=8'h01, idx<=EXP_W-1, go to SQR.
  - SQR: busy=1. r<=r·r.
    - If e_q[idx]=1, go to MUL.
    - Else if idx==0, go to DONE.
    - Else idx<=idx-1, stay in SQR.
  - MUL: busy=1. r<=r·a_q.
    - If idx==0, go to DONE.
    - Else idx<=idx-1, go to SQR.
  - DONE: busy=0, done=1 for exactly this cycle, p<=r (p visible from the same cycle via a registered copy: p is loaded on the transition into DONE). Next state is IDLE. If start=1 in DONE, it is accepted as in IDLE and the next state is SQR (back-to-back operation).
- Latency: start sampled at rising edge k. Exactly EXP_W+popcount(e) busy cycles follow, and done is high in cycle k+1+EXP_W+popcount(e). Latency depends only on e, never on a. Examples: e=247 or e=251 (popcount 7) gives done at k+16; e=0 gives k+9.
- start while busy=1 is ignored. There is no queuing, and inputs a/e may change freely after acceptance.
- Edge-case arithmetic:
  - 0^0 = 1 (r stays 1 because no MUL occurs).
  - 0^e = 0 for e≠0.
  - a^255 = 1 for a≠0.
  - No width growth: all values stay 8-bit field elements.
- done and busy are never high in the same cycle. p changes only on entry to DONE or on reset.

Test Plan:
- Reset/idle: assert rst mid-operation (cycle 5 after start, a=0x02, e=0xF7) -> busy=0, done=0, p=0x00 immediately; no done pulse afterwards; a new start then runs normally.
- Basic powers: a=0x02 with e=1 -> p=0x02; e=2 -> p=0x04; e=8 -> p=0x63. done at k+10, k+10 and k+10 respectively (popcount 1 each).
- Inverse/order: a=0x02, e=254 -> p=0xB1 at k+16. a=0x02, e=255 -> p=0x01 at k+17. a=0x00, e=0 -> p=0x01 at k+9. a=0x00, e=247 -> p=0x00.
- S-box exponents: for all 256 values of a with e=247 and e=251, compare p against a reference-model GF power. done must be at k+16 every time.
- Handshake: start held high continuously with e=0x01 -> operations run back-to-back, done every 10 cycles with no idle gap. A start pulse while busy=1 (with different a) does not alter the result.
- Input stability: change a and e every cycle after acceptance -> result equals the power of the values latched at acceptance; p is stable between done pulses.
